// File: rtl/soc_multi_timer_if.sv
// Bus interface for soc_multi_timer.
// Carries the Avalon-style slave signals between a bus master and the timer block.
//   chipselect : slave select
//   write_n    : active-low write strobe
//   address    : word address {channel, reg[2:0]}
//   writedata  : write data
//   readdata   : registered read data (one cycle latency)
interface soc_multi_timer_if #(
    parameter int ADDR_W = 5
);
    logic              chipselect;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output chipselect, write_n, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write_n, address, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_multi_timer.sv
// Multi-channel down-counting timer with per-channel timeout interrupt and PWM.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : register access interface (slave modport)
//   irq      : OR of irq_vec
//   irq_vec  : per-channel interrupt, TO & ITO
//   pwm_out  : per-channel registered PWM output
// Per-channel register map (address = {channel, reg}):
//   0 STATUS {RUN, TO} | 1 CONTROL {PWM_EN, STOP, START, CONT, ITO}
//   2 PERIOD | 3 COMPARE | 4 SNAP | 5-7 reserved (read 0)
module soc_multi_timer #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PERIOD_RST = 49999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    soc_multi_timer_if.slave     bus,
    output logic                 irq,
    output logic [NUM_CH-1:0]    irq_vec,
    output logic [NUM_CH-1:0]    pwm_out
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = 3 + CH_W;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_SNAP    = 3'd4;

    localparam logic [CNT_W-1:0] PERIOD_RST_C = CNT_W'(PERIOD_RST);

    logic [CH_W-1:0] sel_ch;
    logic [2:0]      sel_reg;
    logic            wr_en;
    logic [31:0]     rd_val [NUM_CH];
    logic [31:0]     rd_mux;

    assign sel_ch  = bus.address[ADDR_W-1:3];
    assign sel_reg = bus.address[2:0];
    assign wr_en   = bus.chipselect && !bus.write_n;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] period;
            logic [CNT_W-1:0] compare;
            logic [CNT_W-1:0] snap;
            logic [4:0]       ctrl;
            logic             run;
            logic             to;
            logic             reload_q;
            logic             pwm;
            logic             sel;
            logic             tmo;
            logic             ctl_wr;

            assign sel    = wr_en && (int'(sel_ch) == c);
            assign ctl_wr = sel && (sel_reg == REG_CONTROL);
            assign tmo    = run && (cnt == '0);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= PERIOD_RST_C;
                    period   <= PERIOD_RST_C;
                    compare  <= '0;
                    snap     <= '0;
                    ctrl     <= '0;
                    run      <= 1'b0;
                    to       <= 1'b0;
                    reload_q <= 1'b0;
                    pwm      <= 1'b0;
                end else begin
                    // A PERIOD write forces a reload/stop on the following edge.
                    reload_q <= sel && (sel_reg == REG_PERIOD);

                    if (sel && (sel_reg == REG_PERIOD))  period  <= bus.writedata[CNT_W-1:0];
                    if (sel && (sel_reg == REG_COMPARE)) compare <= bus.writedata[CNT_W-1:0];
                    if (ctl_wr)                          ctrl    <= bus.writedata[4:0];
                    if (sel && (sel_reg == REG_SNAP))    snap    <= cnt;

                    // Timeout beats a same-cycle STATUS clear.
                    if (tmo)
                        to <= 1'b1;
                    else if (sel && (sel_reg == REG_STATUS))
                        to <= 1'b0;

                    if (reload_q || tmo)
                        cnt <= period;
                    else if (run)
                        cnt <= cnt - CNT_W'(1);

                    // START overrides STOP, the forced reload stop and one-shot expiry.
                    if (ctl_wr && bus.writedata[2])
                        run <= 1'b1;
                    else if (ctl_wr && bus.writedata[3])
                        run <= 1'b0;
                    else if (reload_q)
                        run <= 1'b0;
                    else if (tmo && !ctrl[1])
                        run <= 1'b0;

                    pwm <= ctrl[4] && run && (cnt < compare);
                end
            end

            assign rd_val[c] = (sel_reg == REG_STATUS)  ? {30'd0, run, to} :
                               (sel_reg == REG_CONTROL) ? {27'd0, ctrl}    :
                               (sel_reg == REG_PERIOD)  ? 32'(period)      :
                               (sel_reg == REG_COMPARE) ? 32'(compare)     :
                               (sel_reg == REG_SNAP)    ? 32'(snap)        :
                                                          32'd0;

            assign irq_vec[c] = to && ctrl[0];
            assign pwm_out[c] = pwm;
        end
    endgenerate

    // Channel indices beyond NUM_CH fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel_ch) == i) rd_mux = rd_val[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign irq = |irq_vec;
endmodule

// File: tb/tb_soc_multi_timer.sv
// Self-checking bench for soc_multi_timer: directed scenarios plus random register
// traffic checked against a behavioural model of the register/timer rules.
module tb_soc_multi_timer;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic       irq, irq_s;
    logic [3:0] irq_vec, pwm_out;
    logic [2:0] irq_vec_s, pwm_s;
    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;

    soc_multi_timer_if #(.ADDR_W(5)) bus ();
    soc_multi_timer_if #(.ADDR_W(5)) bus_s ();

    soc_multi_timer dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .irq(irq), .irq_vec(irq_vec), .pwm_out(pwm_out)
    );

    soc_multi_timer #(.NUM_CH(3), .CNT_W(16)) u_small (
        .clk(clk), .reset_n(reset_n), .bus(bus_s),
        .irq(irq_s), .irq_vec(irq_vec_s), .pwm_out(pwm_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the default instance (4 channels, 32-bit).
    logic [31:0] m_cnt [4];
    logic [31:0] m_per [4];
    logic [31:0] m_cmp [4];
    logic [31:0] m_snap[4];
    logic [4:0]  m_ctrl[4];
    bit          m_run [4];
    bit          m_to  [4];
    bit          m_rel [4];
    bit          m_pwm [4];
    logic [31:0] m_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] = 49999; m_per[k] = 49999; m_cmp[k] = 0; m_snap[k] = 0;
                m_ctrl[k] = 0; m_run[k] = 0; m_to[k] = 0; m_rel[k] = 0; m_pwm[k] = 0;
            end
            m_rd = 0;
        end else begin
            int  ch, rg;
            bit  wr;
            ch = int'(bus.address[4:3]);
            rg = int'(bus.address[2:0]);
            wr = bus.chipselect && !bus.write_n;
            case (rg)
                0: m_rd = {30'd0, m_run[ch], m_to[ch]};
                1: m_rd = {27'd0, m_ctrl[ch]};
                2: m_rd = m_per[ch];
                3: m_rd = m_cmp[ch];
                4: m_rd = m_snap[ch];
                default: m_rd = 0;
            endcase
            for (int k = 0; k < 4; k++) begin
                bit w, tmo, nrun;
                w   = wr && (ch == k);
                tmo = m_run[k] && (m_cnt[k] == 0);
                m_pwm[k] = m_ctrl[k][4] && m_run[k] && (m_cnt[k] < m_cmp[k]);
                if (w && rg == 4) m_snap[k] = m_cnt[k];
                nrun = m_run[k];
                if (tmo && !m_ctrl[k][1]) nrun = 0;
                if (m_rel[k]) nrun = 0;
                if (w && rg == 1 && bus.writedata[3]) nrun = 0;
                if (w && rg == 1 && bus.writedata[2]) nrun = 1;
                if (m_rel[k] || tmo) m_cnt[k] = m_per[k];
                else if (m_run[k]) m_cnt[k] = m_cnt[k] - 1;
                if (tmo) m_to[k] = 1;
                else if (w && rg == 0) m_to[k] = 0;
                m_rel[k] = w && (rg == 2);
                if (w && rg == 2) m_per[k] = bus.writedata;
                if (w && rg == 3) m_cmp[k] = bus.writedata;
                if (w && rg == 1) m_ctrl[k] = bus.writedata[4:0];
                m_run[k] = nrun;
            end
        end
    end

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        bus.address = 5'(ch * 8 + rg); bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] d);
        @(negedge clk);
        bus.address = 5'(ch * 8 + rg);
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic wr_s(input int ch, input int rg, input logic [31:0] d);
        @(negedge clk);
        bus_s.chipselect = 1'b1; bus_s.write_n = 1'b0;
        bus_s.address = 5'(ch * 8 + rg); bus_s.writedata = d;
        @(negedge clk);
        bus_s.chipselect = 1'b0; bus_s.write_n = 1'b1;
    endtask

    task automatic rd_s(input int ch, input int rg, output logic [31:0] d);
        @(negedge clk);
        bus_s.address = 5'(ch * 8 + rg);
        @(negedge clk);
        d = bus_s.readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%0h exp=0", irq); end
        n_cmp++; if (irq_vec !== 4'h0) begin n_bad++; $display("FAIL reset_irq_vec got=%0h exp=0", irq_vec); end
        n_cmp++; if (pwm_out !== 4'h0) begin n_bad++; $display("FAIL reset_pwm got=%0h exp=0", pwm_out); end
        n_cmp++; if (bus.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got=%0h exp=0", bus.readdata); end
        reset_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            rd(ch, 2, d);
            n_cmp++; if (d !== 32'd49999) begin n_bad++; $display("FAIL reset_period ch%0d got=%0h exp=%0h", ch, d, 49999); end
            rd(ch, 0, d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status ch%0d got=%0h exp=0", ch, d); end
            rd(ch, 1, d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_control ch%0d got=%0h exp=0", ch, d); end
        end
    endtask

    task automatic test_continuous;
        longint t0, t1;
        logic [31:0] d;
        wr(0, 2, 9);
        wr(0, 1, 32'h7);
        for (int i = 0; i < 40 && !irq; i++) @(negedge clk);
        t0 = cyc;
        n_cmp++; if (irq_vec !== 4'b0001) begin n_bad++; $display("FAIL cont_irq_vec got=%0h exp=1", irq_vec); end
        wr(0, 0, 0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL cont_clear got=%0h exp=0", irq); end
        for (int i = 0; i < 30 && !irq; i++) @(negedge clk);
        t1 = cyc;
        n_cmp++; if (t1 - t0 != 10) begin n_bad++; $display("FAIL cont_interval got=%0d exp=10", t1 - t0); end
        rd(0, 0, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL cont_status got=%0h exp=3", d); end
    endtask

    task automatic test_oneshot;
        int j;
        logic [31:0] d;
        wr(1, 2, 4);
        wr(1, 1, 32'h4);
        bus.address = 5'(1 * 8 + 0);
        j = 0;
        while (j < 20) begin
            @(negedge clk);
            j++;
            if (bus.readdata[0]) break;
        end
        // 5 cycles to expire plus one cycle of read latency.
        n_cmp++; if (j != 6) begin n_bad++; $display("FAIL oneshot_latency got=%0d exp=6", j); end
        n_cmp++; if (bus.readdata !== 32'h1) begin n_bad++; $display("FAIL oneshot_status got=%0h exp=1", bus.readdata); end
        wr(1, 0, 0);
        repeat (20) @(negedge clk);
        rd(1, 0, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL oneshot_no_repeat got=%0h exp=0", d); end
        wr(1, 4, 0);
        rd(1, 4, d);
        n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL oneshot_count got=%0h exp=4", d); end
    endtask

    task automatic test_pwm;
        int hi;
        wr(2, 2, 99);
        wr(2, 3, 25);
        wr(2, 1, 32'h16);
        repeat (5) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (pwm_out[2]) hi++; end
        n_cmp++; if (hi != 50) begin n_bad++; $display("FAIL pwm_duty got=%0d exp=50", hi); end
        wr(2, 3, 0);
        repeat (3) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 150; i++) begin @(negedge clk); if (pwm_out[2]) hi++; end
        n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL pwm_cmp0 got=%0d exp=0", hi); end
        wr(2, 3, 200);
        repeat (3) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 150; i++) begin @(negedge clk); if (pwm_out[2]) hi++; end
        n_cmp++; if (hi != 150) begin n_bad++; $display("FAIL pwm_cmp_big got=%0d exp=150", hi); end
    endtask

    task automatic test_status_clear;
        for (int i = 0; i < 30 && !(m_run[0] && m_cnt[0] == 0); i++) @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 5'd0; bus.writedata = 0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL status_coincident got=%0h exp=1", irq); end
        for (int i = 0; i < 30 && m_cnt[0] != 5; i++) @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 5'd0; bus.writedata = 0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL status_clear_irq got=%0h exp=0", irq); end
        n_cmp++; if (irq_vec !== 4'h0) begin n_bad++; $display("FAIL status_clear_vec got=%0h exp=0", irq_vec); end
    endtask

    task automatic test_snap_reload;
        logic [31:0] d;
        wr(3, 2, 32'h2000);
        wr(3, 1, 32'h4);
        for (int i = 0; i < 9000 && m_cnt[3] != 32'h1234; i++) @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 5'(3 * 8 + 4); bus.writedata = 0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        rd(3, 4, d);
        n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL snap_value got=%0h exp=1234", d); end
        rd(3, 0, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL snap_running got=%0h exp=2", d); end
        rd(2, 4, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL snap_other_ch got=%0h exp=0", d); end
        wr(3, 2, 32'h500);
        rd(3, 0, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reload_run got=%0h exp=0", d); end
        wr(3, 4, 0);
        rd(3, 4, d);
        n_cmp++; if (d !== 32'h500) begin n_bad++; $display("FAIL reload_count got=%0h exp=500", d); end
    endtask

    task automatic test_random;
        logic [3:0] e_vec, e_pwm;
        for (int i = 0; i < 800; i++) begin
            int ch, rg;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                e_vec[k] = m_to[k] && m_ctrl[k][0];
                e_pwm[k] = m_pwm[k];
            end
            n_cmp++; if (bus.readdata !== m_rd) begin n_bad++; $display("FAIL rand_readdata it%0d got=%0h exp=%0h", i, bus.readdata, m_rd); end
            n_cmp++; if (irq_vec !== e_vec) begin n_bad++; $display("FAIL rand_irq_vec it%0d got=%0h exp=%0h", i, irq_vec, e_vec); end
            n_cmp++; if (irq !== (|e_vec)) begin n_bad++; $display("FAIL rand_irq it%0d got=%0h exp=%0h", i, irq, |e_vec); end
            n_cmp++; if (pwm_out !== e_pwm) begin n_bad++; $display("FAIL rand_pwm it%0d got=%0h exp=%0h", i, pwm_out, e_pwm); end
            ch = $urandom_range(0, 3);
            rg = $urandom_range(0, 7);
            bus.address = 5'(ch * 8 + rg);
            if ($urandom_range(0, 9) < 4) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                case (rg)
                    1: bus.writedata = $urandom_range(0, 31);
                    2: bus.writedata = $urandom_range(0, 30);
                    3: bus.writedata = $urandom_range(0, 35);
                    default: bus.writedata = $urandom;
                endcase
            end else begin
                bus.chipselect = $urandom_range(0, 1); bus.write_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic test_small;
        logic [31:0] d;
        rd_s(0, 2, d);
        n_cmp++; if (d !== 32'd49999) begin n_bad++; $display("FAIL small_reset_period got=%0h exp=%0h", d, 49999); end
        wr_s(0, 2, 32'hABCD1234);
        rd_s(0, 2, d);
        n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL small_trunc got=%0h exp=1234", d); end
        wr_s(3, 2, 32'h55);
        rd_s(3, 2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL small_ch3 got=%0h exp=0", d); end
        rd_s(0, 2, d);
        n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL small_ch0_kept got=%0h exp=1234", d); end
        wr_s(1, 2, 3);
        wr_s(1, 1, 32'h7);
        for (int i = 0; i < 20 && !irq_s; i++) @(negedge clk);
        n_cmp++; if (irq_vec_s !== 3'b010) begin n_bad++; $display("FAIL small_irq_vec got=%0h exp=2", irq_vec_s); end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] d;
        wr(0, 1, 32'h7);
        repeat (12) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0 || irq_s !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got=%0h/%0h exp=0", irq, irq_s); end
        n_cmp++; if (irq_vec !== 4'h0 || pwm_out !== 4'h0) begin n_bad++; $display("FAIL midreset_vec got=%0h/%0h exp=0", irq_vec, pwm_out); end
        n_cmp++; if (bus.readdata !== 32'h0) begin n_bad++; $display("FAIL midreset_readdata got=%0h exp=0", bus.readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            rd(ch, 0, d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_status ch%0d got=%0h exp=0", ch, d); end
            rd(ch, 2, d);
            n_cmp++; if (d !== 32'd49999) begin n_bad++; $display("FAIL midreset_period ch%0d got=%0h exp=%0h", ch, d, 49999); end
        end
        rd_s(0, 2, d);
        n_cmp++; if (d !== 32'd49999) begin n_bad++; $display("FAIL midreset_small got=%0h exp=%0h", d, 49999); end
        repeat (20) @(negedge clk);
        n_cmp++; if (irq !== 1'b0 || pwm_out !== 4'h0) begin n_bad++; $display("FAIL midreset_idle got=%0h/%0h exp=0", irq, pwm_out); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
        bus_s.chipselect = 1'b0; bus_s.write_n = 1'b1; bus_s.address = '0; bus_s.writedata = '0;
        test_reset();
        test_continuous();
        test_oneshot();
        test_pwm();
        test_status_clear();
        test_snap_reload();
        test_random();
        test_small();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
